// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side command path.
package uart_pkg;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    DATA,
    CHK,
    OUT
  } parser_state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout for uart_cmd_parser; only instantiated when
// UART_CMD_PARSER_TIMEOUT_EN is defined.
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_WIDTH       = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic pop,
  output logic expire
);

  localparam logic [TO_WIDTH-1:0] TERM = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] r_cnt;

  // Down-counter reloaded on every pop; terminal count means TIMEOUT_CYCLES empty cycles.
  assign expire = active && !pop && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || !active || pop) begin
      r_cnt <= TERM;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TO_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Deframes A5 | cmd | payload | checksum from the rx FIFO into command words.
// Optional inter-byte timeout: define UART_CMD_PARSER_TIMEOUT_EN.
//   state | meaning
//   HUNT  | discard bytes until the 0xA5 sync byte
//   CMD   | latch wr/addr, seed running sum
//   DATA  | collect DATA_BYTES payload bytes, little-endian
//   CHK   | checksum byte must bring the sum to zero
//   OUT   | present command, hold until accepted
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_WIDTH       = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_empty,
  input  logic [DATA_BITS-1:0]    rd_data,
  output logic                    rd_uart,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_wr,
  output logic [6:0]              cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_data,
  output logic                    chk_err,
  output logic                    timeout_err,
  output logic [7:0]              err_cnt
);

  localparam int unsigned IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  if (DATA_BITS != 8 || DATA_BYTES < 1 || DATA_BYTES > 8 ||
      TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES >= 2**TO_WIDTH) begin : g_bad_cfg
    $error("uart_cmd_parser: unsupported parameter set");
  end

  parser_state_t r_state, w_next;

  logic                    w_pop;
  logic                    w_chk_fail;
  logic                    w_expire;
  logic [7:0]              w_byte;
  logic [7:0]              w_sum_chk;
  logic [7:0]              r_sum;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_wr;
  logic [6:0]              r_addr;
  logic [8*DATA_BYTES-1:0] r_data;
  logic                    r_chk_err;
  logic                    r_to_err;
  logic [7:0]              r_err_cnt;

  assign w_byte    = rd_data[7:0];
  assign w_pop     = !rx_empty && (r_state != OUT);
  assign w_sum_chk = r_sum + w_byte;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  logic w_active;

  assign w_active = (r_state == CMD) || (r_state == DATA) || (r_state == CHK);

  uart_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .active (w_active),
    .pop    (w_pop),
    .expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_chk_fail = 1'b0;
    case (r_state)
      HUNT: if (w_pop && w_byte == UART_SYNC_BYTE) w_next = CMD;
      CMD:  if (w_pop) w_next = DATA;
      DATA: if (w_pop && r_idx == LAST_IDX) w_next = CHK;
      CHK: begin
        if (w_pop) begin
          if (w_sum_chk == 8'h00) begin
            w_next = OUT;
          end else begin
            w_next     = HUNT;
            w_chk_fail = 1'b1;
          end
        end
      end
      OUT:  if (cmd_ready) w_next = HUNT;
      default: w_next = HUNT;
    endcase
    // Expiry only fires on an empty cycle, so it never competes with a pop.
    if (w_expire) w_next = HUNT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum     <= '0;
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_chk_err <= 1'b0;
      r_to_err  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_chk_err <= w_chk_fail;
      r_to_err  <= w_expire;
      if (w_pop) begin
        case (r_state)
          CMD: begin
            r_wr   <= w_byte[7];
            r_addr <= w_byte[6:0];
            r_sum  <= w_byte;
            r_idx  <= '0;
          end
          DATA: begin
            r_data[{r_idx, 3'b000} +: 8] <= w_byte;
            r_sum <= w_sum_chk;
            r_idx <= r_idx + IDX_W'(1);
          end
          default: ;
        endcase
      end
      if ((w_chk_fail || w_expire) && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign rd_uart     = w_pop && !reset;
  assign cmd_valid   = (r_state == OUT);
  assign cmd_wr      = r_wr;
  assign cmd_addr    = r_addr;
  assign cmd_data    = r_data;
  assign chk_err     = r_chk_err;
  assign timeout_err = r_to_err;
  assign err_cnt     = r_err_cnt;

endmodule
